counter_down_timer: RTL and testbench

COUNTER_DOWN_TIMER -- requirements
Module: counter_down_timer

---
 rtl/counter_down_timer_if.sv | 24 ++
 rtl/counter_down_timer.sv | 99 +++++++++
 tb/tb_counter_down_timer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_down_timer_if.sv
// Control and status bundle for the down-counting timer.
// master drives commands and load value; slave returns count, busy and done.
interface counter_down_timer_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter;
  logic             busy;
  logic             done;

  modport master (
    output clear, start, stop, auto_reload, load_value,
    input  counter, busy, done
  );

  modport slave (
    input  clear, start, stop, auto_reload, load_value,
    output counter, busy, done
  );
endinterface

// File: rtl/counter_down_timer.sv
// Loadable down-counter with pause/resume and optional auto-reload; all outputs registered.
// Counter updates on the edge that samples a command; done follows the zero-handling edge by one cycle.
module counter_down_timer #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 200
) (
  input  logic                  clk,
  input  logic                  RST,
  counter_down_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_nxt;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             busy_q;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = (bus.load_value > MAX_W) ? MAX_W : bus.load_value;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      counter_q <= counter_nxt;
      reload_q  <= reload_nxt;
      done_q    <= done_nxt;
      busy_q    <= (state_nxt != IDLE);
    end
  end

  // clear beats stop beats start in every state; a stop on the zero edge defers done
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter_q;
    reload_nxt  = reload_q;
    done_nxt    = 1'b0;

    if (bus.clear) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.stop && bus.start) begin
            counter_nxt = load_clamped;
            reload_nxt  = load_clamped;
            state_nxt   = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_nxt = PAUSE;
          end else if (counter_q != '0) begin
            counter_nxt = counter_q - WIDTH'(1);
          end else begin
            done_nxt = 1'b1;
            if (bus.auto_reload) begin
              counter_nxt = reload_q;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        PAUSE: begin
          if (!bus.stop && bus.start) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = '0;
        end
      endcase
    end
  end

  assign bus.counter = counter_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_counter_down_timer.sv
// Directed-vector bench for counter_down_timer (WIDTH=4, MAX_VALUE=13) with a queue-based scoreboard.
module tb_counter_down_timer;

  typedef struct {
    logic [3:0] c;
    logic       b;
    logic       d;
    string      nm;
  } exp_t;

  logic clk;
  logic RST;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  counter_down_timer_if #(.WIDTH(4)) bus();

  counter_down_timer #(.WIDTH(4), .MAX_VALUE(13)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic clr, input logic st, input logic sp, input logic ar,
                      input logic [3:0] ld, input logic [3:0] ec, input logic eb,
                      input logic ed, input string nm);
    exp_t e;
    @(negedge clk);
    bus.clear       = clr;
    bus.start       = st;
    bus.stop        = sp;
    bus.auto_reload = ar;
    bus.load_value  = ld;
    e.c  = ec;
    e.b  = eb;
    e.d  = ed;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising edge the DUT presents a new registered state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.nm, ".counter"}, int'(bus.counter), int'(e.c));
        check({e.nm, ".busy"},    int'(bus.busy),    int'(e.b));
        check({e.nm, ".done"},    int'(bus.done),    int'(e.d));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b0;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.auto_reload = 1'b0;
    bus.load_value = 4'd0;
    #2 RST = 1'b1;
    #1;
    check("reset.counter", int'(bus.counter), 0);
    check("reset.busy",    int'(bus.busy),    0);
    check("reset.done",    int'(bus.done),    0);
    repeat (2) @(posedge clk);
    @(negedge clk) RST = 1'b0;

    step(0,0,0,0,4'd0, 4'd0,0,0, "idle_after_reset");

    // one-shot from 5
    step(0,1,0,0,4'd5, 4'd5,1,0, "oneshot_load");
    for (int i = 4; i >= 0; i--) step(0,0,0,0,4'd0, 4'(i),1,0, "oneshot_count");
    step(0,0,0,0,4'd0, 4'd0,0,1, "oneshot_done");
    step(0,0,0,0,4'd0, 4'd0,0,0, "oneshot_after");
    step(0,0,0,0,4'd0, 4'd0,0,0, "oneshot_hold");

    // clamp 15 -> 13
    step(0,1,0,0,4'd15, 4'd13,1,0, "clamp_load");
    for (int i = 12; i >= 0; i--) step(0,0,0,0,4'd0, 4'(i),1,0, "clamp_count");
    step(0,0,0,0,4'd0, 4'd0,0,1, "clamp_done");
    step(0,0,0,0,4'd0, 4'd0,0,0, "clamp_after");

    // auto-reload period 3, then drop auto_reload
    step(0,1,0,1,4'd2, 4'd2,1,0, "ar_load");
    step(0,0,0,1,4'd0, 4'd1,1,0, "ar_c1a");
    step(0,0,0,1,4'd0, 4'd0,1,0, "ar_c0a");
    step(0,0,0,1,4'd0, 4'd2,1,1, "ar_reload1");
    step(0,0,0,1,4'd0, 4'd1,1,0, "ar_c1b");
    step(0,0,0,1,4'd0, 4'd0,1,0, "ar_c0b");
    step(0,0,0,1,4'd0, 4'd2,1,1, "ar_reload2");
    step(0,0,0,1,4'd0, 4'd1,1,0, "ar_c1c");
    step(0,0,0,0,4'd0, 4'd0,1,0, "ar_drop_c0");
    step(0,0,0,0,4'd0, 4'd0,0,1, "ar_final_done");
    step(0,0,0,0,4'd0, 4'd0,0,0, "ar_idle");

    // pause at 3, hold, start+stop stays paused, resume
    step(0,1,0,0,4'd6, 4'd6,1,0, "pause_load");
    step(0,0,0,0,4'd0, 4'd5,1,0, "pause_c5");
    step(0,0,0,0,4'd0, 4'd4,1,0, "pause_c4");
    step(0,0,0,0,4'd0, 4'd3,1,0, "pause_c3");
    step(0,0,1,0,4'd0, 4'd3,1,0, "pause_enter");
    for (int i = 0; i < 3; i++) step(0,0,0,0,4'd0, 4'd3,1,0, "pause_hold");
    step(0,1,1,0,4'd0, 4'd3,1,0, "pause_start_stop");
    step(0,1,0,0,4'd0, 4'd3,1,0, "pause_resume");
    step(0,0,0,0,4'd0, 4'd2,1,0, "resume_c2");
    step(0,0,0,0,4'd0, 4'd1,1,0, "resume_c1");
    step(0,0,0,0,4'd0, 4'd0,1,0, "resume_c0");
    step(0,0,0,0,4'd0, 4'd0,0,1, "resume_done");
    step(0,0,0,0,4'd0, 4'd0,0,0, "resume_after");

    // stop coincides with zero: no done until resumed
    step(0,1,0,1,4'd1, 4'd1,1,0, "stopzero_load");
    step(0,0,0,1,4'd0, 4'd0,1,0, "stopzero_c0");
    step(0,0,1,1,4'd0, 4'd0,1,0, "stopzero_pause");
    step(0,1,0,0,4'd0, 4'd0,1,0, "stopzero_resume");
    step(0,0,0,0,4'd0, 4'd0,0,1, "stopzero_done");
    step(0,0,0,0,4'd0, 4'd0,0,0, "stopzero_after");

    // start while running is ignored
    step(0,1,0,0,4'd4, 4'd4,1,0, "runstart_load");
    step(0,1,0,0,4'd9, 4'd3,1,0, "runstart_ignored");
    step(0,0,0,0,4'd0, 4'd2,1,0, "runstart_c2");
    step(0,0,0,0,4'd0, 4'd1,1,0, "runstart_c1");
    step(0,0,0,0,4'd0, 4'd0,1,0, "runstart_c0");
    step(0,0,0,0,4'd0, 4'd0,0,1, "runstart_done");
    step(0,0,0,0,4'd0, 4'd0,0,0, "runstart_after");

    // clear beats stop and start in RUN; stop beats start in IDLE
    step(0,1,0,0,4'd8, 4'd8,1,0, "prio_load");
    step(0,0,0,0,4'd0, 4'd7,1,0, "prio_c7");
    step(1,1,1,0,4'd5, 4'd0,0,0, "prio_clear");
    step(0,0,0,0,4'd0, 4'd0,0,0, "prio_nodone");
    step(0,1,1,0,4'd5, 4'd0,0,0, "idle_stop_beats_start");
    step(1,1,0,0,4'd5, 4'd0,0,0, "idle_clear_beats_start");

    // zero load, one-shot then auto-reload
    step(0,1,0,0,4'd0, 4'd0,1,0, "zero_load");
    step(0,0,0,0,4'd0, 4'd0,0,1, "zero_done");
    step(0,0,0,0,4'd0, 4'd0,0,0, "zero_after");
    step(0,1,0,1,4'd0, 4'd0,1,0, "zero_ar_load");
    for (int i = 0; i < 3; i++) step(0,0,0,1,4'd0, 4'd0,1,1, "zero_ar_done");
    step(1,0,0,1,4'd0, 4'd0,0,0, "zero_ar_clear");
    step(0,0,0,0,4'd0, 4'd0,0,0, "zero_ar_after");

    // reach counter 7, then async reset between edges
    step(0,1,0,0,4'd9, 4'd9,1,0, "rst_load");
    step(0,0,0,0,4'd0, 4'd8,1,0, "rst_c8");
    step(0,0,0,0,4'd0, 4'd7,1,0, "rst_c7");
    @(posedge clk);
    #3;
    check("pre_rst.queue_drained", exp_q.size(), 0);
    check("pre_rst.counter", int'(bus.counter), 7);
    RST = 1'b1;
    #1;
    check("async_rst.counter", int'(bus.counter), 0);
    check("async_rst.busy",    int'(bus.busy),    0);
    check("async_rst.done",    int'(bus.done),    0);
    repeat (2) @(posedge clk);
    @(negedge clk) RST = 1'b0;
    for (int i = 0; i < 4; i++) step(0,0,0,0,4'd0, 4'd0,0,0, "post_rst_idle");
    step(0,1,0,0,4'd2, 4'd2,1,0, "post_rst_load");
    step(0,0,0,0,4'd0, 4'd1,1,0, "post_rst_c1");

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
